// File: rtl/btb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : btb_pkg
// Purpose  : Shared constants, entry type and PC field helpers for btb_tagged.
// Revision : 1.0 - initial tagged BTB release
// ---------------------------------------------------------------------------
package btb_pkg;

  localparam logic [1:0] CTR_WEAK_T = 2'b10;
  localparam logic [1:0] CTR_MAX    = 2'b11;
  localparam logic [1:0] CTR_MIN    = 2'b00;

  localparam int TAG_MAX_W = 31;
  localparam int PC_MAX_W  = 64;

  // Widest-case entry view; the top narrows fields to its own TAG_W/XLEN.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [PC_MAX_W-1:0]  target;
    logic [1:0]           ctr;
  } btb_entry_t;

  function automatic logic [31:0] btb_index(input logic [PC_MAX_W-1:0] pc,
                                            input int idx_w);
    return 32'((pc >> 1) & ((64'd1 << idx_w) - 64'd1));
  endfunction

  function automatic logic [31:0] btb_tag(input logic [PC_MAX_W-1:0] pc,
                                          input int idx_w,
                                          input int tag_w);
    return 32'((pc >> (idx_w + 1)) & ((64'd1 << tag_w) - 64'd1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/btb_sat_ctr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : btb_sat_ctr
// Purpose  : 2-bit saturating direction counter next-state (BTB_CTR_EN only).
// Revision : 1.0 - initial tagged BTB release
// ---------------------------------------------------------------------------
`ifdef BTB_CTR_EN
module btb_sat_ctr
  import btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_MIN) ctr_next = ctr - 2'd1;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/btb_tagged.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : btb_tagged
// Purpose  : Tagged direct-mapped BTB, registered lookup, write-first update.
//            Optional macro BTB_CTR_EN adds 2-bit direction counters.
// Revision : 1.0 - initial tagged BTB release
// ---------------------------------------------------------------------------
module btb_tagged
  import btb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            lk_valid,
  input  logic [XLEN-1:0] lk_pc,
  output logic            rsp_valid,
  output logic            rsp_hit,
  output logic            rsp_taken,
  output logic [XLEN-1:0] rsp_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [XLEN-1:0]    tgt_mem [ENTRIES];
`ifdef BTB_CTR_EN
  logic [1:0]         ctr_mem [ENTRIES];
  logic [1:0]         ctr_next;
`endif

  logic [PC_MAX_W-1:0]  lk_pc_x, upd_pc_x;
  logic [31:0]          lk_idx_full, lk_tag_full, upd_idx_full, upd_tag_full;
  logic [IDX_W-1:0]     lk_idx, upd_idx;
  logic [TAG_MAX_W-1:0] lk_tag, upd_tag;

  assign lk_pc_x      = PC_MAX_W'(lk_pc);
  assign upd_pc_x     = PC_MAX_W'(upd_pc);
  assign lk_idx_full  = btb_index(lk_pc_x, IDX_W);
  assign upd_idx_full = btb_index(upd_pc_x, IDX_W);
  assign lk_tag_full  = btb_tag(lk_pc_x, IDX_W, TAG_W);
  assign upd_tag_full = btb_tag(upd_pc_x, IDX_W, TAG_W);
  assign lk_idx       = lk_idx_full[IDX_W-1:0];
  assign upd_idx      = upd_idx_full[IDX_W-1:0];
  assign lk_tag       = lk_tag_full[TAG_MAX_W-1:0];
  assign upd_tag      = upd_tag_full[TAG_MAX_W-1:0];

  btb_entry_t upd_old, lk_old, new_e, lk_e;
  logic       upd_hit, wr_en, lk_hit, lk_taken;

  always_comb begin
    upd_old        = '0;
    upd_old.valid  = valid_q[upd_idx];
    upd_old.tag    = TAG_MAX_W'(tag_mem[upd_idx]);
    upd_old.target = PC_MAX_W'(tgt_mem[upd_idx]);
    lk_old         = '0;
    lk_old.valid   = valid_q[lk_idx];
    lk_old.tag     = TAG_MAX_W'(tag_mem[lk_idx]);
    lk_old.target  = PC_MAX_W'(tgt_mem[lk_idx]);
`ifdef BTB_CTR_EN
    upd_old.ctr    = ctr_mem[upd_idx];
    lk_old.ctr     = ctr_mem[lk_idx];
`endif
  end

  assign upd_hit = upd_old.valid && (upd_old.tag == upd_tag);

`ifdef BTB_CTR_EN
  btb_sat_ctr u_sat_ctr (
    .ctr      (upd_old.ctr),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );
`endif

  // Post-update view of the indexed entry; flush drops the update entirely.
  always_comb begin
    new_e = upd_old;
    wr_en = 1'b0;
    if (upd_valid && !flush) begin
      if (upd_hit) begin
        if (upd_taken) new_e.target = PC_MAX_W'(upd_target);
`ifdef BTB_CTR_EN
        new_e.ctr = ctr_next;
        wr_en     = 1'b1;
`else
        wr_en     = upd_taken;
`endif
      end else if (upd_taken) begin
        new_e.valid  = 1'b1;
        new_e.tag    = upd_tag;
        new_e.target = PC_MAX_W'(upd_target);
        new_e.ctr    = CTR_WEAK_T;
        wr_en        = 1'b1;
      end
    end
  end

  // Write-first bypass: a lookup of the entry being written sees the new value.
  assign lk_e   = (wr_en && (upd_idx == lk_idx)) ? new_e : lk_old;
  assign lk_hit = lk_valid && !flush && lk_e.valid && (lk_e.tag == lk_tag);
`ifdef BTB_CTR_EN
  assign lk_taken = lk_hit && lk_e.ctr[1];
`else
  assign lk_taken = lk_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[upd_idx] <= new_e.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_mem[upd_idx] <= new_e.tag[TAG_W-1:0];
      tgt_mem[upd_idx] <= new_e.target[XLEN-1:0];
`ifdef BTB_CTR_EN
      ctr_mem[upd_idx] <= new_e.ctr;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_taken  <= 1'b0;
      rsp_target <= '0;
    end else begin
      rsp_valid  <= lk_valid;
      rsp_hit    <= lk_hit;
      rsp_taken  <= lk_taken;
      rsp_target <= lk_hit ? lk_e.target[XLEN-1:0] : '0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{lk_idx_full, upd_idx_full, lk_tag_full, upd_tag_full,
                         new_e, lk_e, upd_old.ctr, lk_old.ctr};

endmodule
`default_nettype wire

// File: tb/tb_btb_tagged.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_btb_tagged
// Purpose  : Self-checking bench for btb_tagged against an abstract BTB model.
// Revision : 1.0 - initial tagged BTB release
// ---------------------------------------------------------------------------
module tb_btb_tagged;

  localparam int ENTRIES = 16;
  localparam int TAG_W   = 8;
  localparam int XLEN    = 32;

  logic            clk = 1'b0;
  logic            rst, flush, lk_valid, upd_valid, upd_taken;
  logic [XLEN-1:0] lk_pc, upd_pc, upd_target;
  logic            rsp_valid, rsp_hit, rsp_taken;
  logic [XLEN-1:0] rsp_target;

  int total = 0;
  int bad   = 0;

  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int unsigned m_ctr   [ENTRIES];

  btb_tagged #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .lk_valid   (lk_valid),
    .lk_pc      (lk_pc),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .rsp_taken  (rsp_taken),
    .rsp_target (rsp_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned m_idx(input int unsigned pc);
    return (pc / 2) % ENTRIES;
  endfunction

  function automatic int unsigned m_tagof(input int unsigned pc);
    return (pc / (2 * ENTRIES)) % (1 << TAG_W);
  endfunction

  // One clock: drive inputs, advance the model to its post-edge state and
  // compare the registered response against what that state implies.
  task automatic step(input bit fl, input bit lkv, input int unsigned lpc,
                      input bit uv, input int unsigned upc,
                      input int unsigned utgt, input bit utk);
    int unsigned i, t;
    bit          e_hit, e_taken;
    int unsigned e_tgt;
    flush = fl; lk_valid = lkv; lk_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = utk;
    if (uv && !fl) begin
      i = m_idx(upc); t = m_tagof(upc);
      if (m_valid[i] && m_tag[i] == t) begin
        if (utk) m_tgt[i] = utgt;
        if (utk && m_ctr[i] < 3) m_ctr[i]++;
        if (!utk && m_ctr[i] > 0) m_ctr[i]--;
      end else if (utk) begin
        m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = utgt; m_ctr[i] = 2;
      end
    end
    if (fl) foreach (m_valid[k]) m_valid[k] = 0;
    i = m_idx(lpc);
    e_hit = lkv && !fl && m_valid[i] && (m_tag[i] == m_tagof(lpc));
`ifdef BTB_CTR_EN
    e_taken = e_hit && (m_ctr[i] >= 2);
`else
    e_taken = e_hit;
`endif
    e_tgt = e_hit ? m_tgt[i] : 0;
    @(posedge clk); #1;
    chk("rsp_valid",  rsp_valid,  lkv);
    chk("rsp_hit",    rsp_hit,    e_hit);
    chk("rsp_taken",  rsp_taken,  e_taken);
    chk("rsp_target", rsp_target, e_tgt);
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0;
    lk_valid = 1; lk_pc = 32'h1000;
    foreach (m_valid[k]) m_valid[k] = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_rsp_valid",  rsp_valid,  0);
    chk("reset_rsp_hit",    rsp_hit,    0);
    chk("reset_rsp_taken",  rsp_taken,  0);
    chk("reset_rsp_target", rsp_target, 0);
    rst = 0; lk_valid = 0;
  endtask

  initial begin
    do_reset();

    // Cold lookup misses.
    step(0, 1, 32'h1000, 0, 0, 0, 0);
    chk("cold_hit", rsp_hit, 0);

    // Allocate then look up.
    step(0, 0, 0, 1, 32'h1000, 32'h2000, 1);
    chk("idle_rsp_valid", rsp_valid, 0);
    step(0, 1, 32'h1000, 0, 0, 0, 0);
    chk("alloc_hit", rsp_hit, 1);
    chk("alloc_target", rsp_target, 32'h2000);

    // Same index, different tag.
    step(0, 1, 32'h1000 + (ENTRIES << 1), 0, 0, 0, 0);
    chk("alias_hit", rsp_hit, 0);

    // Counter walk: not-taken weakens, then taken saturates.
    step(0, 0, 0, 1, 32'h1000, 32'h3000, 0);
    step(0, 1, 32'h1000, 0, 0, 0, 0);
    chk("nt_hit", rsp_hit, 1);
`ifdef BTB_CTR_EN
    chk("nt_taken", rsp_taken, 0);
`else
    chk("nt_taken", rsp_taken, 1);
`endif
    chk("nt_target_kept", rsp_target, 32'h2000);
    repeat (3) step(0, 0, 0, 1, 32'h1000, 32'h2000, 1);
    step(0, 1, 32'h1000, 1, 32'h1000, 32'h2000, 0);
`ifdef BTB_CTR_EN
    chk("sat_then_nt_taken", rsp_taken, 1);
`endif

    // Write-first allocation at an empty index.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h1040, 1, 32'h1040, 32'h5550, 1);
    chk("wf_hit", rsp_hit, 1);
    chk("wf_target", rsp_target, 32'h5550);

    // Flush after several allocations, then flush with an update.
    for (int n = 0; n < 6; n++) step(0, 0, 0, 1, 32'h1000 + 2 * n, 32'h8000 + 16 * n, 1);
    step(1, 1, 32'h1002, 0, 0, 0, 0);
    chk("flush_same_cycle_hit", rsp_hit, 0);
    for (int n = 0; n < 6; n++) begin
      step(0, 1, 32'h1000 + 2 * n, 0, 0, 0, 0);
      chk("post_flush_hit", rsp_hit, 0);
    end
    step(1, 0, 0, 1, 32'h1000, 32'h9000, 1);
    step(0, 1, 32'h1000, 0, 0, 0, 0);
    chk("flush_drops_update", rsp_hit, 0);

    // Randomised traffic over a small PC window for plenty of aliasing.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
           32'h1000 + 2 * $urandom_range(0, 127),
           ($urandom_range(0, 3) != 0), 32'h1000 + 2 * $urandom_range(0, 127),
           $urandom & 32'hffff_fffe, $urandom_range(0, 1));
    end

    // Reset while a lookup is in flight.
    do_reset();
    step(0, 1, 32'h1040, 0, 0, 0, 0);
    chk("post_reset_hit", rsp_hit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
